// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit sequencer.
// Holds the controller state encoding and the default parameter values.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam int DATA_W_DEF      = 8;
  localparam int GAP_CYC_DEF     = 16;
  localparam int TIMEOUT_CYC_DEF = 2048;
  localparam int CNT_W_DEF       = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_cyc_timer.sv
// Loadable down-counter with a zero flag.
// Saturates at zero; load has priority over decrement.
module uart_cyc_timer #(
  parameter int W = 11
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// Sequencer between the UART TX FIFO and the UART transmitter.
// Pops, loads, strobes start, waits for done, then holds the gap.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int GAP_CYC     = GAP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic              fifo_empty_in,
  output logic              fifo_rd_en_out,
  input  logic [DATA_W-1:0] fifo_data_in,
  input  logic              tx_busy_in,
  input  logic              tx_done_in,
  output logic              tx_start_out,
  output logic [DATA_W-1:0] tx_data_out,
  output logic [CNT_W-1:0]  frame_cnt_out,
  output logic              idle_out,
  output logic              err_out,
  input  logic              err_clr_in
);

  localparam int TW = $clog2(max2(TIMEOUT_CYC, GAP_CYC));
  localparam bit HAS_GAP = (GAP_CYC > 0);
  localparam logic [TW-1:0] TO_LD = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(HAS_GAP ? GAP_CYC - 1 : 0);

  state_t        state;
  logic          tmr_load;
  logic          tmr_dec;
  logic          tmr_zero;
  logic [TW-1:0] tmr_val;

  // Timeout count spans START plus WAIT_DONE, so it is loaded leaving LOAD.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TO_LD;
    tmr_dec  = 1'b0;
    if (state == S_LOAD) begin
      tmr_load = 1'b1;
    end else if (state == S_WAIT && tx_done_in && HAS_GAP) begin
      tmr_load = 1'b1;
      tmr_val  = GAP_LD;
    end else begin
      tmr_dec = (state == S_START) ||
                (state == S_WAIT) ||
                (state == S_GAP);
    end
  end

  uart_cyc_timer #(
    .W (TW)
  ) u_tmr (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      fifo_rd_en_out <= 1'b0;
      tx_start_out   <= 1'b0;
      tx_data_out    <= '0;
      frame_cnt_out  <= '0;
      idle_out       <= 1'b1;
      err_out        <= 1'b0;
    end else begin
      fifo_rd_en_out <= 1'b0;
      tx_start_out   <= 1'b0;
      if (err_clr_in) err_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (en_in && !fifo_empty_in && !tx_busy_in) begin
            state          <= S_POP;
            fifo_rd_en_out <= 1'b1;
            idle_out       <= 1'b0;
          end
        end
        S_POP: state <= S_LOAD;
        S_LOAD: begin
          tx_data_out  <= fifo_data_in;
          tx_start_out <= 1'b1;
          state        <= S_START;
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (tx_done_in) begin
            frame_cnt_out <= frame_cnt_out + CNT_W'(1);
            if (HAS_GAP) begin
              state <= S_GAP;
            end else begin
              state    <= S_IDLE;
              idle_out <= 1'b1;
            end
          end else if (tmr_zero) begin
            err_out  <= 1'b1;
            state    <= S_IDLE;
            idle_out <= 1'b1;
          end
        end
        S_GAP: begin
          if (tmr_zero) begin
            state    <= S_IDLE;
            idle_out <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          idle_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl with FIFO and transmitter models.
// Frame timing is predicted arithmetically from the gap/timeout rules.
module tb_uart_tx_ctrl;

  localparam int G  = 5;
  localparam int T  = 48;
  localparam int CW = 4;
  localparam int NF = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in;
  logic          en_in;
  logic          fifo_empty_in;
  logic          fifo_rd_en_out;
  logic [7:0]    fifo_data_in;
  logic          tx_busy_in;
  logic          tx_done_in;
  logic          tx_start_out;
  logic [7:0]    tx_data_out;
  logic [CW-1:0] frame_cnt_out;
  logic          idle_out;
  logic          err_out;
  logic          err_clr_in;

  uart_tx_ctrl #(
    .DATA_W      (8),
    .GAP_CYC     (G),
    .TIMEOUT_CYC (T),
    .CNT_W       (CW)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .en_in          (en_in),
    .fifo_empty_in  (fifo_empty_in),
    .fifo_rd_en_out (fifo_rd_en_out),
    .fifo_data_in   (fifo_data_in),
    .tx_busy_in     (tx_busy_in),
    .tx_done_in     (tx_done_in),
    .tx_start_out   (tx_start_out),
    .tx_data_out    (tx_data_out),
    .frame_cnt_out  (frame_cnt_out),
    .idle_out       (idle_out),
    .err_out        (err_out),
    .err_clr_in     (err_clr_in)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_at = -1;
  int dly_def = 6;
  int rd_cnt = 0;
  int bad_pop = 0;
  int last_start = -1;
  bit pop_pend = 0;
  bit busy_force = 0;
  logic [7:0] fifo_q[$];
  int dly_q[$];
  int start_cyc_q[$];
  logic [7:0] start_dat_q[$];

  typedef struct {
    bit en;
    bit has;
    bit busy;
    int exp_rd;
  } row_t;
  row_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    int d;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_pend) begin
      if (fifo_q.size() > 0) fifo_data_in = fifo_q.pop_front();
      pop_pend = 0;
    end
    if (fifo_rd_en_out) begin
      rd_cnt++;
      if (fifo_q.size() == 0) bad_pop++;
      else pop_pend = 1;
    end
    fifo_empty_in = (fifo_q.size() == 0);
    tx_done_in = (cyc == done_at);
    if (tx_start_out) begin
      last_start = cyc;
      start_cyc_q.push_back(cyc);
      start_dat_q.push_back(tx_data_out);
      d = (dly_q.size() > 0) ? dly_q.pop_front() : dly_def;
      done_at = (d > 0) ? cyc + d : -1;
    end
    tx_busy_in = busy_force || (done_at > cyc);
  endtask

  task automatic wait_start(input string nm, input int lim);
    int s0 = last_start;
    int n = 0;
    while (last_start == s0 && n < lim) begin
      step();
      n++;
    end
    if (last_start == s0) begin
      total++;
      bad++;
      $display("FAIL %s: no tx_start_out within %0d cycles", nm, lim);
    end
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    while (idle_out !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    if (idle_out !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: idle_out=%b expected 1 within %0d", nm,
               idle_out, lim);
    end
  endtask

  task automatic do_reset();
    rst_in = 1;
    en_in = 0;
    err_clr_in = 0;
    busy_force = 0;
    fifo_q.delete();
    dly_q.delete();
    done_at = -1;
    pop_pend = 0;
    step();
    step();
    rst_in = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_rd"}, 32'(fifo_rd_en_out), 0);
    chk({nm, "_start"}, 32'(tx_start_out), 0);
    chk({nm, "_data"}, 32'(tx_data_out), 0);
    chk({nm, "_cnt"}, 32'(frame_cnt_out), 0);
    chk({nm, "_idle"}, 32'(idle_out), 1);
    chk({nm, "_err"}, 32'(err_out), 0);
  endtask

  initial begin
    int n0;
    int rd0;
    int s;
    int exp_cnt;
    int es;
    int dones;
    bit any_to;
    int dl[NF];
    logic [7:0] bl[NF];

    rst_in = 1;
    en_in = 0;
    fifo_empty_in = 1;
    fifo_data_in = 8'h00;
    tx_busy_in = 0;
    tx_done_in = 0;
    err_clr_in = 0;
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 0};
    tbl[3] = '{0, 1, 1, 0};
    tbl[4] = '{1, 0, 0, 0};
    tbl[5] = '{1, 0, 1, 0};
    tbl[6] = '{1, 1, 0, 1};
    tbl[7] = '{1, 1, 1, 0};

    do_reset();
    chk_reset_vals("rst");

    // IDLE launch condition matrix
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].has) fifo_q.push_back(8'(8'hA0 + i));
      en_in = tbl[i].en;
      busy_force = tbl[i].busy;
      rd0 = rd_cnt;
      repeat (4) step();
      chk($sformatf("tbl%0d_rd", i), 32'(rd_cnt - rd0), 32'(tbl[i].exp_rd));
      en_in = 0;
      busy_force = 0;
      if (tbl[i].exp_rd != 0) wait_idle($sformatf("tbl%0d_idle", i), 100);
      fifo_q.delete();
      repeat (2) step();
    end

    // Single frame latency and gap length
    do_reset();
    en_in = 1;
    dly_def = 6;
    fifo_q.push_back(8'h5A);
    step();
    n0 = cyc;
    step();
    chk("lat_rd_n1", 32'(fifo_rd_en_out), 1);
    chk("lat_start_n1", 32'(tx_start_out), 0);
    step();
    chk("lat_rd_n2", 32'(fifo_rd_en_out), 0);
    chk("lat_start_n2", 32'(tx_start_out), 0);
    step();
    chk("lat_start_n3", 32'(tx_start_out), 1);
    chk("lat_data_n3", 32'(tx_data_out), 32'h5A);
    step();
    chk("lat_start_n4", 32'(tx_start_out), 0);
    while (cyc < n0 + 9) step();
    chk("cnt_before_done", 32'(frame_cnt_out), 0);
    step();
    chk("cnt_after_done", 32'(frame_cnt_out), 1);
    chk("idle_gap_first", 32'(idle_out), 0);
    while (cyc < n0 + 9 + G) step();
    chk("idle_gap_last", 32'(idle_out), 0);
    step();
    chk("idle_after_gap", 32'(idle_out), 1);
    chk("data_held", 32'(tx_data_out), 32'h5A);
    exp_cnt = 1;

    // Done coincident with timer expiry: done wins
    dly_q.push_back(T - 1);
    fifo_q.push_back(8'h21);
    wait_start("tie_start", 20);
    wait_idle("tie_idle", T + G + 10);
    exp_cnt++;
    chk("tie_err", 32'(err_out), 0);
    chk("tie_cnt", 32'(frame_cnt_out), 32'(exp_cnt));

    // Stuck transmitter
    dly_q.push_back(0);
    fifo_q.push_back(8'h33);
    wait_start("to_start", 20);
    s = last_start;
    n0 = 0;
    while (err_out !== 1'b1 && n0 < T + 10) begin
      step();
      n0++;
    end
    chk("to_latency", 32'(cyc - s), 32'(T));
    chk("to_cnt", 32'(frame_cnt_out), 32'(exp_cnt));
    chk("to_idle", 32'(idle_out), 1);
    err_clr_in = 1;
    step();
    err_clr_in = 0;
    chk("err_clr", 32'(err_out), 0);

    dly_q.push_back(0);
    fifo_q.push_back(8'h34);
    wait_start("to2_start", 20);
    repeat (T - 1) step();
    chk("to2_pre", 32'(err_out), 0);
    err_clr_in = 1;
    step();
    err_clr_in = 0;
    chk("to2_set_wins", 32'(err_out), 1);
    err_clr_in = 1;
    step();
    err_clr_in = 0;
    chk("to2_clr", 32'(err_out), 0);

    // Enable dropped mid-frame
    start_dat_q.delete();
    dly_def = 8;
    fifo_q.push_back(8'h61);
    fifo_q.push_back(8'h62);
    fifo_q.push_back(8'h63);
    wait_start("en_start", 20);
    en_in = 0;
    rd0 = rd_cnt;
    repeat (40) step();
    exp_cnt++;
    chk("en_no_pop", 32'(rd_cnt - rd0), 0);
    chk("en_cnt", 32'(frame_cnt_out), 32'(exp_cnt));
    chk("en_fifo_left", 32'(fifo_q.size()), 2);
    en_in = 1;
    wait_start("en_s2", 60);
    wait_start("en_s3", 60);
    wait_idle("en_idle", 60);
    exp_cnt += 2;
    chk("en_cnt3", 32'(frame_cnt_out), 32'(exp_cnt % (1 << CW)));
    chk("en_order", {start_dat_q[0], start_dat_q[1], start_dat_q[2]},
        32'h616263);

    // Reset while waiting for done
    dly_def = 6;
    fifo_q.push_back(8'h77);
    wait_start("rw_start", 20);
    step();
    step();
    rst_in = 1;
    en_in = 0;
    step();
    rst_in = 0;
    chk_reset_vals("rw");
    rd0 = rd_cnt;
    repeat (8) step();
    chk("rw_cnt", 32'(frame_cnt_out), 0);
    chk("rw_idle", 32'(idle_out), 1);
    chk("rw_no_pop", 32'(rd_cnt - rd0), 0);

    // Busy transmitter blocks launch
    fifo_q.push_back(8'h88);
    busy_force = 1;
    en_in = 1;
    rd0 = rd_cnt;
    repeat (10) step();
    chk("busy_no_pop", 32'(rd_cnt - rd0), 0);
    busy_force = 0;
    wait_start("busy_start", 20);
    chk("busy_data", 32'(tx_data_out), 32'h88);
    wait_idle("busy_idle", 40);
    chk("busy_cnt", 32'(frame_cnt_out), 1);

    // Randomized run with counter wrap
    do_reset();
    start_cyc_q.delete();
    start_dat_q.delete();
    dones = 0;
    any_to = 0;
    for (int k = 0; k < NF; k++) begin
      bl[k] = 8'($urandom);
      if (k >= 17 && $urandom_range(0, 2) == 0) dl[k] = 0;
      else dl[k] = $urandom_range(1, T - 1);
      if (dl[k] > 0) dones++;
      else any_to = 1;
      fifo_q.push_back(bl[k]);
      dly_q.push_back(dl[k]);
    end
    rd0 = rd_cnt;
    en_in = 1;
    step();
    n0 = cyc;
    s = 0;
    while (start_cyc_q.size() < NF && s < 6000) begin
      step();
      s++;
    end
    wait_idle("rnd_idle", T + G + 10);
    es = n0 + 3;
    for (int k = 0; k < NF; k++) begin
      if (k < start_cyc_q.size()) begin
        chk($sformatf("rnd_cyc%0d", k), 32'(start_cyc_q[k]), 32'(es));
        chk($sformatf("rnd_dat%0d", k), 32'(start_dat_q[k]), 32'(bl[k]));
      end else begin
        chk($sformatf("rnd_missing%0d", k), 32'(start_cyc_q.size()),
            32'(NF));
      end
      es += ((dl[k] > 0) ? dl[k] + 1 + G : T) + 3;
    end
    chk("rnd_cnt", 32'(frame_cnt_out), 32'(dones % (1 << CW)));
    chk("rnd_err", 32'(err_out), 32'(any_to));
    chk("rnd_rd", 32'(rd_cnt - rd0), 32'(NF));
    chk("no_empty_pop", 32'(bad_pop), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Sequencer between the UART transmit FIFO and the UART transmitter.
- Pops one byte from the FIFO whenever the FIFO is non-empty, the transmitter is idle and the block is enabled.
- Presents the byte to the transmitter with a one-cycle start strobe, then waits for the transmitter's done pulse.
- Enforces a programmable inter-frame gap, counts transmitted frames and flags a stuck transmitter by timeout.

Parameters:
- DATA_W, 8, width of FIFO and transmitter data.
- GAP_CYC, 16, idle cycles inserted after each completed frame; 0 means no gap.
- TIMEOUT_CYC, 2048, maximum cycles in WAIT_DONE before abort; must be at least 2.
- CNT_W, 16, width of frame counter.

Ports:
- clk_in  input  1  single system clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- en_in  input  1  enable; sampled only in IDLE.
- fifo_empty_in  input  1  TX FIFO empty flag.
- fifo_rd_en_out  output  1  FIFO read strobe; exactly one cycle per pop.
- fifo_data_in  input  DATA_W  FIFO read data; valid the cycle after fifo_rd_en_out.
- tx_busy_in  input  1  transmitter is shifting a frame.
- tx_done_in  input  1  one-cycle pulse at end of the stop bit.
- tx_start_out  output  1  one-cycle start strobe to the transmitter.
- tx_data_out  output  DATA_W  byte to transmit; held stable from START until the next LOAD.
- frame_cnt_out  output  CNT_W  completed-frame count; wraps modulo 2^CNT_W.
- idle_out  output  1  high only in IDLE.
- err_out  output  1  sticky timeout flag.
- err_clr_in  input  1  clears err_out.

Behaviour:
- Reset (synchronous, rst_in=1 at a rising edge):
  - State goes to IDLE.
  - fifo_rd_en_out=0, tx_start_out=0, tx_data_out=0, frame_cnt_out=0, err_out=0, idle_out=1.
  - Timer is cleared.
  - Reset mid-frame aborts without any further pop or start; the FIFO byte already popped is lost.
- All outputs are registered and decoded from state and registers; there are no combinational input-to-output paths.
- States: IDLE, POP, LOAD, START, WAIT_DONE, GAP.
  - IDLE: goes to POP when en_in=1, fifo_empty_in=0 and tx_busy_in=0 are all true in the same cycle; otherwise stays in IDLE.
  - POP: fifo_rd_en_out=1 for this cycle only. Always goes to LOAD.
  - LOAD: tx_data_out is captured from fifo_data_in at the end of this cycle. Goes to START.
  - START: tx_start_out=1 for this cycle only. The timer is loaded with TIMEOUT_CYC-1. Goes to WAIT_DONE.
  - WAIT_DONE:
    - On tx_done_in=1: frame_cnt_out increments (wraps from all-ones to 0). Goes to GAP if GAP_CYC>0, else IDLE.
    - Otherwise, when the timer reaches 0: err_out is set, the frame is not counted, and the state goes to IDLE.
    - The timer decrements every cycle in this state.
    - If tx_done_in and timer expiry occur in the same cycle, done wins and no error is set.
  - GAP: the timer is loaded with GAP_CYC-1 on entry. Goes to IDLE when the timer reaches 0, so GAP lasts exactly GAP_CYC cycles.
- tx_done_in pulses outside WAIT_DONE are ignored.
- Latency: with the IDLE condition true in cycle N:
  - fifo_rd_en_out is high in N+1.
  - Data is captured in N+2.
  - tx_start_out is high in N+3 with tx_data_out already valid.
- en_in deasserted mid-frame does not abort; the frame completes and the block then stays in IDLE.
- fifo_empty_in is checked only in IDLE, so the block never pops an empty FIFO.
- err_out:
  - Set by a timeout; cleared by err_clr_in=1.
  - A timeout set and err_clr_in in the same cycle: set wins.
  - err_out does not block operation.
- Back-to-back frames with GAP_CYC=0 and continuous data: 4 cycles of overhead per frame beyond transmitter time.

Decomposition:
- Shared package uart_pkg holds:
  - The state enum and its encoding.
  - Default DATA_W=8.
  - Default GAP_CYC, TIMEOUT_CYC and CNT_W constants.
- One sub-module, uart_cyc_timer: a loadable down-counter with a zero flag, shared between the GAP and WAIT_DONE states. Its width is clog2 of the maximum of TIMEOUT_CYC and GAP_CYC.

Test Plan:
1. Reset, then en_in=1, FIFO holding 0x5A, tx_busy_in=0 → fifo_rd_en_out high for 1 cycle at N+1; tx_start_out high at N+3 with tx_data_out=0x5A; done pulse → frame_cnt_out=1, idle_out=1 after 16 gap cycles.
2. 16 bytes 0x00..0x0F with GAP_CYC=0 and transmitter done 10 cycles after each start → bytes emitted in order, frame_cnt_out=16, exactly 16 read strobes, no read while fifo_empty_in=1.
3. Transmitter never pulses done, TIMEOUT_CYC=2048 → err_out=1 exactly 2048 cycles after tx_start_out, frame_cnt_out unchanged; err_clr_in pulse → err_out=0; err_clr_in coincident with a new timeout → err_out stays 1.
4. en_in dropped during WAIT_DONE with 3 bytes queued → current frame completes and is counted; no further fifo_rd_en_out until en_in=1.
5. rst_in asserted in WAIT_DONE → next cycle all outputs at reset values, frame_cnt_out=0; the previously pending tx_done_in is ignored.
6. CNT_W=4, 17 frames → frame_cnt_out wraps to 1; tx_busy_in=1 held in IDLE with a non-empty FIFO → no pop until tx_busy_in=0.
